// File: rtl/mem_arbiter_if.sv
// Bundle of instruction, data and memory request/response signals for mem_arbiter.
// master = arbiter view; slave = requesters plus memory.
interface mem_arbiter_if;
  logic        i_req_valid;
  logic [31:0] i_addr;
  logic        i_req_ack;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rack;

  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ack;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rack;

  logic [31:0] m_addr;
  logic        m_rd;
  logic        m_wr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_req_ack;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rack;

  modport master (
    input  i_req_valid, i_addr, i_rack,
    input  d_rd, d_wr, d_addr, d_wdata, d_wstrb, d_rack,
    input  m_req_ack, m_rdata, m_rvalid,
    output i_req_ack, i_rdata, i_rvalid,
    output d_req_ack, d_rdata, d_rvalid,
    output m_addr, m_rd, m_wr, m_wdata, m_wstrb, m_rack
  );

  modport slave (
    output i_req_valid, i_addr, i_rack,
    output d_rd, d_wr, d_addr, d_wdata, d_wstrb, d_rack,
    output m_req_ack, m_rdata, m_rvalid,
    input  i_req_ack, i_rdata, i_rvalid,
    input  d_req_ack, d_rdata, d_rvalid,
    input  m_addr, m_rd, m_wr, m_wdata, m_wstrb, m_rack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one memory port, one transaction in flight, alternating on ties.
// Grant one cycle after a request is seen idle; ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_arbiter #(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   cnt_i_grant,
  output logic [31:0]   cnt_d_grant,
  output logic [31:0]   cnt_conflict
`endif
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GNT_I = 5'b00010,
    RSP_I = 5'b00100,
    GNT_D = 5'b01000,
    RSP_D = 5'b10000
  } state_t;

  state_t state, state_next;
  logic   last_gnt;
  logic   req_i, req_d;
  logic   enter_i, enter_d;

  assign req_i   = bus.i_req_valid;
  assign req_d   = bus.d_rd | bus.d_wr;
  assign enter_i = (state == IDLE) && (state_next == GNT_I);
  assign enter_d = (state == IDLE) && (state_next == GNT_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= ~INIT_PRIO;
    end else begin
      state <= state_next;
      if (enter_i)
        last_gnt <= 1'b0;
      else if (enter_d)
        last_gnt <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    bus.m_addr    = '0;
    bus.m_rd      = 1'b0;
    bus.m_wr      = 1'b0;
    bus.m_wdata   = '0;
    bus.m_wstrb   = '0;
    bus.m_rack    = 1'b0;
    bus.i_req_ack = 1'b0;
    bus.i_rdata   = '0;
    bus.i_rvalid  = 1'b0;
    bus.d_req_ack = 1'b0;
    bus.d_rdata   = '0;
    bus.d_rvalid  = 1'b0;

    case (state)
      IDLE: begin
        // On a tie, the port that did not win last time goes first.
        if (req_i && (!req_d || last_gnt))
          state_next = GNT_I;
        else if (req_d)
          state_next = GNT_D;
      end

      GNT_I: begin
        if (req_i) begin
          bus.m_addr    = bus.i_addr;
          bus.m_rd      = 1'b1;
          bus.i_req_ack = bus.m_req_ack;
          if (bus.m_req_ack)
            state_next = RSP_I;
        end else begin
          state_next = IDLE;
        end
      end

      GNT_D: begin
        if (req_d) begin
          bus.m_addr    = bus.d_addr;
          bus.m_wdata   = bus.d_wdata;
          bus.m_wstrb   = bus.d_wstrb;
          bus.m_rd      = bus.d_rd & ~bus.d_wr;
          bus.m_wr      = bus.d_wr;
          bus.d_req_ack = bus.m_req_ack;
          if (bus.m_req_ack)
            state_next = bus.d_wr ? IDLE : RSP_D;
        end else begin
          state_next = IDLE;
        end
      end

      RSP_I: begin
        bus.i_rdata  = bus.m_rdata;
        bus.i_rvalid = bus.m_rvalid;
        bus.m_rack   = bus.i_rack;
        if (bus.m_rvalid && bus.i_rack)
          state_next = IDLE;
      end

      RSP_D: begin
        bus.d_rdata  = bus.m_rdata;
        bus.d_rvalid = bus.m_rvalid;
        bus.m_rack   = bus.d_rack;
        if (bus.m_rvalid && bus.d_rack)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i_grant  <= '0;
      cnt_d_grant  <= '0;
      cnt_conflict <= '0;
    end else begin
      if (enter_i)
        cnt_i_grant <= cnt_i_grant + 32'd1;
      if (enter_d)
        cnt_d_grant <= cnt_d_grant + 32'd1;
      if ((state == IDLE) && req_i && req_d)
        cnt_conflict <= cnt_conflict + 32'd1;
    end
  end
`endif

endmodule
